// File: rtl/pt_mem_responder.sv
// Memory-side responder for page-table-walker reads: word-addressed RAM window,
// fixed response latency, in-order queue of outstanding reads, side preload port.
module pt_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid_i,
  output logic        mem_req_ready_o,
  input  logic [31:0] mem_addr_i,
  output logic        mem_resp_valid_o,
  input  logic        mem_resp_ready_i,
  output logic [31:0] mem_data_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic        busy_o
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = $clog2(QDEPTH + 1);
  localparam int unsigned PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [31:0]           r_mem    [WORDS];
  logic [31:0]           r_qdata  [QDEPTH];
  logic [3:0]            r_qtimer [QDEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic [31:0]           w_rd_off;
  logic [31:0]           w_wr_off;
  logic                  w_rd_in;
  logic                  w_wr_in;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic [31:0]           w_rd_data;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_resp_valid;
  logic                  w_unused_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Offset wraps at 32 bits; the upper-bits test rejects anything past the window.
  always_comb begin
    w_rd_off  = mem_addr_i - BASE_ADDR;
    w_wr_off  = wr_addr_i - BASE_ADDR;
    w_rd_in   = (mem_addr_i >= BASE_ADDR) && ((w_rd_off[31:2] >> DEPTH_LOG2) == '0);
    w_wr_in   = (wr_addr_i  >= BASE_ADDR) && ((w_wr_off[31:2] >> DEPTH_LOG2) == '0);
    w_rd_idx  = w_rd_off[DEPTH_LOG2+1:2];
    w_wr_idx  = w_wr_off[DEPTH_LOG2+1:2];
    w_rd_data = w_rd_in ? r_mem[w_rd_idx] : '0;
  end

  assign w_unused_lsbs = ^{w_rd_off[1:0], w_wr_off[1:0]};

  assign mem_req_ready_o  = (r_count < CW'(QDEPTH));
  assign w_resp_valid     = (r_count != '0) && (r_qtimer[r_head] == 4'd0);
  assign mem_resp_valid_o = w_resp_valid;
  assign mem_data_o       = w_resp_valid ? r_qdata[r_head] : '0;
  assign busy_o           = (r_count != '0);
  assign w_accept         = mem_req_valid_i & mem_req_ready_o;
  assign w_pop            = w_resp_valid & mem_resp_ready_i;

  // RAM has no reset so preloaded tables survive rst; async read gives old data on collision.
  always_ff @(posedge clk) begin
    if (wr_en_i && w_wr_in) r_mem[w_wr_idx] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) r_qtimer[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (r_qtimer[i] != 4'd0) r_qtimer[i] <= r_qtimer[i] - 4'd1;
      end
      if (w_accept) begin
        r_qdata[r_tail]  <= w_rd_data;
        r_qtimer[r_tail] <= 4'(LATENCY - 1);
        r_tail           <= ptr_inc(r_tail);
      end
      if (w_pop) r_head <= ptr_inc(r_head);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pt_mem_responder.sv
// Randomized and directed bench for pt_mem_responder against a queue-of-deadlines
// reference model of the response stream.
module tb_pt_mem_responder;

  localparam logic [31:0] BASE    = 32'h0001_0000;
  localparam int          WORDS   = 4096;
  localparam int          LATENCY = 2;
  localparam int          QDEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        busy;

  pt_mem_responder #(
    .BASE_ADDR (BASE),
    .DEPTH_LOG2(12),
    .LATENCY   (LATENCY),
    .QDEPTH    (QDEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_valid_i (req_valid),
    .mem_req_ready_o (req_ready),
    .mem_addr_i      (req_addr),
    .mem_resp_valid_o(resp_valid),
    .mem_resp_ready_i(resp_ready),
    .mem_data_o      (resp_data),
    .wr_en_i         (wr_en),
    .wr_addr_i       (wr_addr),
    .wr_data_i       (wr_data),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } pend_t;

  pend_t       mq[$];
  logic [31:0] m_mem [WORDS];
  bit          m_known = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        s_ready, s_valid;
  logic [31:0] s_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= longint'(BASE)) && ((la - longint'(BASE)) < longint'(4 * WORDS));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  // One clock cycle: drive, compare against model, advance model, cross the edge.
  task automatic step(input logic rv, input logic [31:0] ra, input logic rr,
                      input logic we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic rs);
    bit          mr, mv;
    logic [31:0] md, rdat;
    mr = (mq.size() < QDEPTH);
    mv = (mq.size() > 0) && (mq[0].due <= cyc);
    md = mv ? mq[0].data : 32'h0;
    rst = rs; req_valid = rv; req_addr = ra; resp_ready = rr;
    wr_en = we; wr_addr = wa; wr_data = wd;
    s_ready = req_ready; s_valid = resp_valid; s_data = resp_data;
    if (m_known) begin
      check("ready", {31'h0, req_ready}, {31'h0, mr});
      check("resp_valid", {31'h0, resp_valid}, {31'h0, mv});
      check("resp_data", resp_data, md);
      check("busy", {31'h0, busy}, {31'h0, mq.size() != 0});
    end
    if (rs) mq.delete();
    else begin
      rdat = in_win(ra) ? m_mem[widx(ra)] : 32'h0;
      if (mv && rr) void'(mq.pop_front());
      if (rv && mr) mq.push_back('{data: rdat, due: cyc + LATENCY});
      if (we && in_win(wa)) m_mem[widx(wa)] = wd;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rs) m_known = 1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 32'h0, rr, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 32'h0, 1'b1, 1'b1, a, d, 1'b0);
  endtask

  // Issue one read on an empty queue and check exact arrival cycle and data.
  task automatic rd_wait(input string tag, input logic [31:0] a, input logic [31:0] exp);
    step(1'b1, a, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i < LATENCY; i++) begin
      idle(1'b1);
      check({tag, "_early"}, {31'h0, s_valid}, 32'h0);
    end
    idle(1'b1);
    check({tag, "_valid"}, {31'h0, s_valid}, 32'h1);
    check({tag, "_data"}, s_data, exp);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] d;
    // 1. reset state
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle(1'b0);
    check("rst_ready", {31'h0, s_ready}, 32'h1);
    check("rst_valid", {31'h0, s_valid}, 32'h0);
    check("rst_data", s_data, 32'h0);

    for (int i = 0; i < WORDS; i++) begin
      d = $urandom;
      wr(BASE + 32'(4 * i), d);
    end

    // reset with two reads outstanding drops them
    step(1'b1, 32'h0001_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h0001_0004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("rst_drop_valid", {31'h0, s_valid}, 32'h0);
      check("rst_drop_ready", {31'h0, s_ready}, 32'h1);
    end

    // 2. two-level walk
    wr(32'h0001_0004, 32'h0001_1001);
    wr(32'h0001_1004, 32'h1234_5001);
    rd_wait("walk_l1", 32'h0001_0004, 32'h0001_1001);
    rd_wait("walk_l0", 32'h0001_1004, 32'h1234_5001);

    // 3. out-of-range reads and ignored write (would alias word 0 if decoded wrongly)
    wr(32'h0001_0000, 32'h5A5A_0001);
    rd_wait("oor_low", 32'h0000_0000, 32'h0);
    rd_wait("oor_high", 32'h0001_4000, 32'h0);
    wr(32'h0001_4000, 32'hDEAD_BEEF);
    rd_wait("oor_wr_high", 32'h0001_4000, 32'h0);
    rd_wait("oor_wr_alias", 32'h0001_0000, 32'h5A5A_0001);

    // 4/6. backpressure, then pop while full with a request presented
    wr(32'h0001_0004, 32'h1111_0004);
    wr(32'h0001_0008, 32'h2222_0008);
    step(1'b1, 32'h0001_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h0001_0004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h0001_0008, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check("bp_ready", {31'h0, s_ready}, 32'h0);
      if (i >= 1) check("bp_hold", s_data, 32'h5A5A_0001);
    end
    step(1'b1, 32'h0001_0008, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check("full_pop_ready", {31'h0, s_ready}, 32'h0);
    check("bp_first", s_data, 32'h5A5A_0001);
    step(1'b1, 32'h0001_0008, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check("after_pop_ready", {31'h0, s_ready}, 32'h1);
    check("bp_second", s_data, 32'h1111_0004);
    idle(1'b1);
    idle(1'b1);
    check("bp_third", s_data, 32'h2222_0008);
    idle(1'b1);

    // 5. same-cycle write/read collision
    wr(32'h0001_0010, 32'hAAAA_0001);
    step(1'b1, 32'h0001_0010, 1'b1, 1'b1, 32'h0001_0010, 32'hBBBB_0001, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("coll_old", s_data, 32'hAAAA_0001);
    rd_wait("coll_new", 32'h0001_0010, 32'hBBBB_0001);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra, wa;
      ra = rand_addr();
      wa = rand_addr();
      step(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), wa, $urandom, 1'b0);
    end
    for (int i = 0; i < LATENCY + QDEPTH + 2; i++) idle(1'b1);
    check("drained_busy", {31'h0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
